// File: rtl/store_sequencer_if.sv
// Store-sequencer bus bundle: decoded S-type store in, word-granular memory write out.
// slave is the sequencer side; master is the issuer/memory-model side.
interface store_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        err;

  modport slave (
    input  in_valid, funct3, rs1_val, rs2_val, imm, mem_ack,
    output in_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err
  );

  modport master (
    output in_valid, funct3, rs1_val, rs2_val, imm, mem_ack,
    input  in_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err
  );
endinterface

// File: rtl/store_sequencer.sv
// RV32 store sequencer: turns SB/SH/SW into one or two word-aligned, byte-enabled writes,
// splitting stores that cross a word boundary (or rejecting misaligned ones when SPLIT_EN=0).
module store_sequencer #(
  parameter bit SPLIT_EN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  store_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq1, StReq2, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] rs2_q, rs2_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        err_q, err_d;

  // Lane mask spans two words: bits [3:0] first access, [7:4] second access.
  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] base;
    case (f3)
      3'b000:  base = 8'h01;
      3'b001:  base = 8'h03;
      3'b010:  base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Natural-alignment violation; any store needing a second access is one of these.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b001:  return off[0];
      3'b010:  return |off;
      default: return 1'b0;
    endcase
  endfunction

  logic [31:0] ea_in;
  logic        legal_in;
  logic        reject_in;
  logic [7:0]  mask_q;
  logic [63:0] wide_q;
  logic [31:0] addr1;
  logic [31:0] addr2;

  assign ea_in     = bus.rs1_val + bus.imm;
  assign legal_in  = (bus.funct3[2] == 1'b0) && (bus.funct3[1:0] != 2'b11);
  assign reject_in = (SPLIT_EN == 1'b0) && misaligned(bus.funct3, ea_in[1:0]);

  // Data positioned across a doubleword: low half feeds access 1, high half access 2.
  assign mask_q = lane_mask(funct3_q, ea_q[1:0]);
  assign wide_q = {32'h0, rs2_q} << {ea_q[1:0], 3'b000};
  assign addr1  = {ea_q[31:2], 2'b00};
  assign addr2  = addr1 + 32'd4;

  always_comb begin
    state_d  = state_q;
    ea_d     = ea_q;
    rs2_d    = rs2_q;
    funct3_d = funct3_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          ea_d     = ea_in;
          rs2_d    = bus.rs2_val;
          funct3_d = bus.funct3;
          if (!legal_in || reject_in) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StReq1;
          end
        end
      end
      StReq1: begin
        if (bus.mem_ack) begin
          state_d = (mask_q[7:4] != 4'h0) ? StReq2 : StResp;
        end
      end
      StReq2: begin
        if (bus.mem_ack) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from registered state so reset forces them immediately.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_addr  = addr1;
    bus.mem_wdata = wide_q[31:0];
    bus.mem_be    = 4'h0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.in_ready = 1'b1;
      end
      StReq1: begin
        bus.mem_req = 1'b1;
        bus.mem_be  = mask_q[3:0];
      end
      StReq2: begin
        bus.mem_req   = 1'b1;
        bus.mem_addr  = addr2;
        bus.mem_wdata = wide_q[63:32];
        bus.mem_be    = mask_q[7:4];
      end
      StResp: begin
        bus.done = 1'b1;
        bus.err  = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ea_q     <= 32'h0;
      rs2_q    <= 32'h0;
      funct3_q <= 3'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ea_q     <= ea_d;
      rs2_q    <= rs2_d;
      funct3_q <= funct3_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: table of stores with hand-computed accesses,
// plus reset-state and reset-mid-store sequences. Two DUTs cover both SPLIT_EN settings.
module tb_store_sequencer;

  logic clk;
  logic rst_n;
  logic sel;
  logic in_valid;
  logic [2:0] funct3;
  logic [31:0] rs1_val, rs2_val, imm;
  logic mem_ack;

  logic o_ready, o_req, o_done, o_err;
  logic [31:0] o_addr, o_wdata;
  logic [3:0] o_be;

  int n_checks = 0;
  int n_fail = 0;

  store_sequencer_if bus_a ();
  store_sequencer_if bus_b ();

  store_sequencer #(.SPLIT_EN(1'b1)) u_dut_split (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  store_sequencer #(.SPLIT_EN(1'b0)) u_dut_nosplit (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  assign bus_a.in_valid = in_valid & ~sel;
  assign bus_a.funct3   = funct3;
  assign bus_a.rs1_val  = rs1_val;
  assign bus_a.rs2_val  = rs2_val;
  assign bus_a.imm      = imm;
  assign bus_a.mem_ack  = mem_ack & ~sel;
  assign bus_b.in_valid = in_valid & sel;
  assign bus_b.funct3   = funct3;
  assign bus_b.rs1_val  = rs1_val;
  assign bus_b.rs2_val  = rs2_val;
  assign bus_b.imm      = imm;
  assign bus_b.mem_ack  = mem_ack & sel;

  assign o_ready = sel ? bus_b.in_ready  : bus_a.in_ready;
  assign o_req   = sel ? bus_b.mem_req   : bus_a.mem_req;
  assign o_addr  = sel ? bus_b.mem_addr  : bus_a.mem_addr;
  assign o_wdata = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
  assign o_be    = sel ? bus_b.mem_be    : bus_a.mem_be;
  assign o_done  = sel ? bus_b.done      : bus_a.done;
  assign o_err   = sel ? bus_b.err       : bus_a.err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] rs2;
    int          delay;
    int          nacc;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] w1;
    logic [31:0] a2;
    logic [3:0]  be2;
    logic [31:0] w2;
    bit          err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Latency counts the accepting cycle as 1; done must appear in cycle v.lat.
  task automatic do_store(input vec_t v, input bit release_rst);
    int  lat;
    int  acc;
    int  stall;
    int  reqc;
    bit  done_seen;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    sel = v.sel;
    #1;
    chk("in_ready_before", {31'h0, o_ready}, 32'h1);
    in_valid = 1'b1;
    funct3   = v.f3;
    rs1_val  = v.rs1;
    imm      = v.imm;
    rs2_val  = v.rs2;
    mem_ack  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    acc = 0;
    stall = 0;
    reqc = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(negedge clk);
      lat++;
      if (o_req) begin
        reqc++;
        if (acc == 0) begin
          chk("addr1", o_addr, v.a1);
          chk("be1", {28'h0, o_be}, {28'h0, v.be1});
          chk("wdata1", o_wdata, v.w1);
        end else begin
          chk("addr2", o_addr, v.a2);
          chk("be2", {28'h0, o_be}, {28'h0, v.be2});
          chk("wdata2", o_wdata, v.w2);
        end
        if (stall == v.delay) begin
          mem_ack = 1'b1;
          acc++;
          stall = 0;
        end else begin
          mem_ack = 1'b0;
          stall++;
        end
      end else begin
        mem_ack = 1'b0;
      end
      if (o_done) begin
        done_seen = 1'b1;
        chk("err", {31'h0, o_err}, {31'h0, v.err});
        chk("latency", lat, v.lat);
        chk("n_access", acc, v.nacc);
        if (v.err) chk("req_cycles_on_err", reqc, 0);
      end
    end
    mem_ack = 1'b0;
    if (!done_seen) chk("done_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    rst_n    = 1'b0;
    sel      = 1'b0;
    in_valid = 1'b0;
    funct3   = 3'b000;
    rs1_val  = 32'h0;
    rs2_val  = 32'h0;
    imm      = 32'h0;
    mem_ack  = 1'b0;

    // sel f3 rs1 imm rs2 delay nacc a1 be1 w1 a2 be2 w2 err lat
    vecs.push_back(vec_t'{0, 3'b010, 32'h0000_1000, 32'h10, 32'hA1B2_C3D4, 0, 1,
                          32'h0000_1010, 4'hF, 32'hA1B2_C3D4, 32'h0, 4'h0, 32'h0, 0, 3});
    vecs.push_back(vec_t'{0, 3'b000, 32'h0000_2000, 32'h3, 32'h0000_00EE, 0, 1,
                          32'h0000_2000, 4'h8, 32'hEE00_0000, 32'h0, 4'h0, 32'h0, 0, 3});
    vecs.push_back(vec_t'{0, 3'b010, 32'h0000_3010, 32'hFFFF_FFF2, 32'h1122_3344, 0, 2,
                          32'h0000_3000, 4'hC, 32'h3344_0000,
                          32'h0000_3004, 4'h3, 32'h0000_1122, 0, 4});
    vecs.push_back(vec_t'{0, 3'b001, 32'hFFFF_FFF0, 32'hF, 32'h0000_BEEF, 3, 2,
                          32'hFFFF_FFFC, 4'h8, 32'hEF00_0000,
                          32'h0000_0000, 4'h1, 32'h0000_00BE, 0, 10});
    vecs.push_back(vec_t'{0, 3'b011, 32'h0000_1000, 32'h0, 32'h1234_5678, 0, 0,
                          32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1, 2});
    vecs.push_back(vec_t'{0, 3'b001, 32'h0000_4000, 32'h2, 32'hCAFE_5678, 0, 1,
                          32'h0000_4000, 4'hC, 32'h5678_0000, 32'h0, 4'h0, 32'h0, 0, 3});
    vecs.push_back(vec_t'{0, 3'b000, 32'hFFFF_FFFF, 32'h2, 32'h1234_5678, 1, 1,
                          32'h0000_0000, 4'h2, 32'h3456_7800, 32'h0, 4'h0, 32'h0, 0, 4});
    vecs.push_back(vec_t'{0, 3'b010, 32'h0000_7000, 32'h3, 32'hDEAD_BEEF, 0, 2,
                          32'h0000_7000, 4'h8, 32'hEF00_0000,
                          32'h0000_7004, 4'h7, 32'h00DE_ADBE, 0, 4});
    vecs.push_back(vec_t'{0, 3'b001, 32'h0000_8001, 32'h0, 32'h0000_ABCD, 0, 1,
                          32'h0000_8000, 4'h6, 32'h00AB_CD00, 32'h0, 4'h0, 32'h0, 0, 3});
    vecs.push_back(vec_t'{0, 3'b111, 32'h0000_9000, 32'h0, 32'h0, 0, 0,
                          32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1, 2});
    vecs.push_back(vec_t'{1, 3'b001, 32'h0000_5000, 32'h1, 32'h0000_1234, 0, 0,
                          32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1, 2});
    vecs.push_back(vec_t'{1, 3'b010, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 0, 1,
                          32'h0000_6000, 4'hF, 32'h0BAD_F00D, 32'h0, 4'h0, 32'h0, 0, 3});
    vecs.push_back(vec_t'{1, 3'b010, 32'h0000_6000, 32'h2, 32'h0BAD_F00D, 0, 0,
                          32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1, 2});

    // Reset state, sampled across a rising edge while held in reset.
    #3;
    chk("rst_in_ready", {31'h0, bus_a.in_ready}, 32'h1);
    chk("rst_mem_req", {31'h0, bus_a.mem_req}, 32'h0);
    chk("rst_mem_addr", bus_a.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus_a.mem_wdata, 32'h0);
    chk("rst_mem_be", {28'h0, bus_a.mem_be}, 32'h0);
    chk("rst_done", {31'h0, bus_a.done}, 32'h0);
    chk("rst_err", {31'h0, bus_a.err}, 32'h0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_hold_req", {31'h0, bus_a.mem_req}, 32'h0);
    chk("rst_hold_ready", {31'h0, bus_a.in_ready}, 32'h1);
    in_valid = 1'b0;

    // First store is presented on the same negedge reset releases.
    do_store(vecs[0], 1'b1);

    foreach (vecs[i]) do_store(vecs[i], 1'b0);

    // Reset while access 2 of a split store is stalled.
    sel = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    funct3   = 3'b010;
    rs1_val  = 32'h0000_3002;
    imm      = 32'h0;
    rs2_val  = 32'h1122_3344;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_req1_addr", o_addr, 32'h0000_3000);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("mid_req2_req", {31'h0, o_req}, 32'h1);
    chk("mid_req2_addr", o_addr, 32'h0000_3004);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, o_req}, 32'h0);
    chk("mid_rst_be", {28'h0, o_be}, 32'h0);
    chk("mid_rst_ready", {31'h0, o_ready}, 32'h1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("mid_rst_no_done", {31'h0, o_done}, 32'h0);
    end
    do_store(vecs[2], 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("post_store_idle_done", {31'h0, o_done}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_sequencer.md
STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 The block SHALL have parameter SPLIT_EN, default 1: 1 = split misaligned stores into two word accesses; 0 = flag misaligned stores as error with no access.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  decoded S-type store presented.
REQ-005 in_ready  output  1  block can accept a store.
REQ-006 funct3  input  3  store width: 000 SB, 001 SH, 010 SW; all others illegal.
REQ-007 rs1_val  input  32  base register value.
REQ-008 rs2_val  input  32  store data register value.
REQ-009 imm  input  32  sign-extended S-type immediate.
REQ-010 mem_req  output  1  data-memory write request.
REQ-011 mem_addr  output  32  word-aligned write address (bits[1:0] always 00).
REQ-012 mem_wdata  output  32  lane-positioned write data.
REQ-013 mem_be  output  4  byte enables; bit n = byte lane n.
REQ-014 mem_ack  input  1  memory accepts the current request.
REQ-015 done  output  1  one-cycle pulse: store finished.
REQ-016 err  output  1  valid only with done; 1 = store rejected, no memory write.

Function
REQ-017 The block SHALL have states IDLE, REQ1, REQ2 and RESP; in_ready SHALL be 1 only in IDLE.
REQ-018 A store SHALL be accepted on a rising edge with in_valid=1 in IDLE; the block SHALL register funct3, rs2_val and ea = rs1_val + imm (mod 2^32, carry dropped) at acceptance.
REQ-019 Lane mask SHALL be an 8-bit value: SB 0x01, SH 0x03, SW 0x0F, shifted left by off = ea[1:0].
REQ-020 Access 1 SHALL use mem_addr = {ea[31:2],2'b00}, mem_be = mask[3:0], and mem_wdata = rs2_val << 8*off.
REQ-021 Access 2 SHALL exist only when mask[7:4] != 0.
REQ-022 Access 2 SHALL use mem_addr = access-1 address + 4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), mem_be = mask[7:4], and mem_wdata = rs2_val >> 8*(4-off).
REQ-023 Accepting a legal store SHALL move the block IDLE->REQ1, with mem_req=1 in the cycle after acceptance.
REQ-024 In REQ1 and REQ2, mem_req SHALL be 1 with mem_addr, mem_wdata and mem_be held stable until an edge samples mem_ack=1.
REQ-025 On an ack in REQ1, the block SHALL go to REQ2 if access 2 exists, else to RESP; on an ack in REQ2 it SHALL go to RESP.
REQ-026 mem_ack SHALL be ignored outside REQ1/REQ2, and mem_req SHALL be 0 in IDLE and RESP.
REQ-027 In RESP, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE; back-to-back stores are therefore separated by at least one cycle of in_ready=1.
REQ-028 An illegal funct3 SHALL take the block IDLE->RESP with err=1 and no mem_req.
REQ-029 With SPLIT_EN=0, a store needing access 2 SHALL take IDLE->RESP with err=1 and no mem_req.
REQ-030 Minimum latency SHALL be: aligned store with immediate ack, done 3 cycles after acceptance; split store, 4 cycles.
REQ-031 mem_wdata bits outside enabled lanes are don't-care for the memory; the block SHALL still drive them exactly as REQ-020/REQ-022 define.

Reset
REQ-032 While rst_n=0, the block SHALL drive state IDLE, in_ready=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0 and err=0, asynchronously.
REQ-033 Reset asserted mid-store SHALL drop mem_req immediately, discard the store and produce no done pulse.
REQ-034 After rst_n deasserts, the first rising edge SHALL be able to accept a store.

Verification
REQ-035 Bench SHALL cover SW aligned: rs1=0x1000, imm=0x10, rs2=0xA1B2C3D4, ack immediate -> one access at 0x1010, be=1111, wdata=0xA1B2C3D4, done at +3.
REQ-036 Bench SHALL cover SB with off=3: ea=0x2003, rs2=0x000000EE -> addr 0x2000, be=1000, wdata=0xEE000000, single access.
REQ-037 Bench SHALL cover misaligned SW split: ea=0x3002, rs2=0x11223344 -> access 1 at 0x3000, be=1100, wdata=0x33440000; access 2 at 0x3004, be=0011, wdata=0x00001122; done at +4.
REQ-038 Bench SHALL cover wrap plus ack stall: SH at ea=0xFFFFFFFF, ack delayed 3 cycles -> access 1 at 0xFFFFFFFC be=1000, access 2 at 0x00000000 be=0001, outputs stable during stall.
REQ-039 Bench SHALL cover errors: funct3=011, then SPLIT_EN=0 with SH at ea=0x5001 -> done=1 and err=1 each, mem_req never 1.
REQ-040 Bench SHALL cover reset mid-store: rst_n low while REQ2 is waiting -> mem_req=0 the same cycle, no done, next store accepted normally.
